pic_exec_unit: RTL
==================

# pic_exec_unit

Parametrised, multi-cycle PIC16-class execute unit: W register, STATUS, FSR/INDF indirection and a banked GPR file behind one instruction handshake. It succeeds the single-bank byte/bit/literal ALU, adding configurable bank count and GPR depth, a valid/ready instruction interface, a done/skip completion report and skip instructions (DECFSZ, INCFSZ, BTFSC, BTFSS). It sits between instruction fetch/decode and the program counter logic, which consumes `skip`.

## Interface
- `NUM_BANKS`, 2: register banks (1, 2 or 4); `ADDR_W = 7 + $clog2(NUM_BANKS)` (7 when 1).
- `GPR_DEPTH`, 68: GPR bytes per bank, mapped at f = 0x0C .. 0x0C+GPR_DEPTH-1 (max 116).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  `instr` holds an instruction; hold it stable until accepted.
- `instr_ready`  out  1  unit can accept; transfer when valid && ready.
- `instr`  in  14  PIC16 instruction word.
- `done`  out  1  one-cycle pulse: instruction committed.
- `skip`  out  1  valid with `done`: next instruction must be skipped.
- `unsupported`  out  1  valid with `done`: opcode not executed (treated as NOP).
- `w_reg`  out  8  W register.
- `status`  out  8  STATUS register.
- `dbg_addr`  in  ADDR_W  effective address {bank, f} for debug read.
- `dbg_data`  out  8  combinational read of `dbg_addr` (same map as instruction reads).

## Operation
- Bank select: `{STATUS[6],STATUS[5]}` truncated to bank bits; direct effective address `{bank, f}`.
- f = 0x00 INDF: effective address `{STATUS[7], FSR}` truncated to ADDR_W; INDF via FSR=0x00 reads 0, write ignored.
- f = 0x03 STATUS and 0x04 FSR are shared across banks. STATUS[4:3] (TO, PD) read-only, reset 1.
- Other SFR slots (0x01, 0x02, 0x05–0x0B) and f beyond GPR range: read 0, writes ignored.
- Byte ops (instr[13:12]=00, d=instr[7]): ADDWF, ANDWF, CLRF/CLRW, COMF, DECF, DECFSZ, INCF, INCFSZ, IORWF, MOVF, MOVWF, RLF, RRF, SUBWF, SWAPF, XORWF, NOP. d=0 writes W, d=1 writes f.
- Bit ops (01): BCF, BSF, BTFSC, BTFSS; bit index instr[9:7].
- Literal ops (11): MOVLW, ADDLW, SUBLW, ANDLW, IORLW, XORLW; k=instr[7:0]. RETLW and all 10xx/control opcodes: `unsupported`=1, no state change.
- Flags: Z on ADD/AND/CLR/COM/DEC/INC/IOR/MOVF/SUB/XOR (and literal forms). C, DC on ADD/SUB; SUB C = no borrow (result ≥ 0), DC = no borrow from bit 3. RLF/RRF rotate through C, set C only. DECFSZ/INCFSZ/SWAPF/MOVWF/bit ops: no flags.
- Skip: DECFSZ/INCFSZ result == 0; BTFSC bit == 0; BTFSS bit == 1.
- Writing STATUS with a flag-affecting op: computed flags win for affected bits; other writable bits take the result.
- All arithmetic 8-bit modulo 256; carries from 9-bit sums.

## Timing
- FSM: CLEAR → IDLE → READ → EXEC → WRITE → IDLE.
- Reset: W=00h, STATUS=18h, FSR=00h, done/skip/unsupported=0, instr_ready=0; state CLEAR.
- CLEAR zeroes one GPR per cycle, NUM_BANKS×GPR_DEPTH cycles, then IDLE with instr_ready=1.
- Accept in cycle T (IDLE); READ T+1 latches operand; EXEC T+2 computes result/flags; WRITE T+3 commits and pulses done/skip/unsupported. instr_ready back high at T+4. One instruction per 4 cycles.
- instr_valid while not ready: ignored, not lost if held.
- rst in any state: abort, no commit, no done pulse, re-enter CLEAR.
- dbg_data reflects commits from the cycle after WRITE.

## Structure
- Package `pic_pkg`: opcode localparams, SFR addresses (INDF, STATUS, FSR, GPR base), STATUS bit indices, FSM state enum.
- Sub-module `pic_alu_core`: combinational op/W/f/k/carry-in → result, C, DC, Z, skip, writes_flags, unsupported.
- Top holds FSM, register file, W, STATUS, FSR, address mapping.

## Test plan
- Reset, NUM_BANKS=2, GPR_DEPTH=68 → instr_ready low 136 cycles; W=00h, STATUS=18h, dbg 0x0C=00h.
- MOVLW 95h, MOVWF 0Ch, ADDWF 0Ch,f → F(0Ch)=2Ah, STATUS=19h (C=1, DC=0, Z=0), done 3 cycles after each accept.
- MOVLW 05h, SUBLW 03h → W=FEh, C=0, DC=0, Z=0; SUBLW 05h with W=05h → W=00h, C=1, DC=1, Z=1.
- BSF 03h,5; MOVLW 3Ch; MOVWF 0Ch → dbg 8Ch=3Ch, dbg 0Ch unchanged; FSR=8Ch, INCF 00h,f → dbg 8Ch=3Dh.
- F(0Ch)=01h, DECFSZ 0Ch,f → F=00h, skip=1, STATUS unchanged; BTFSS 03h,2 with Z=0 → skip=0.
- rst asserted during EXEC of ADDWF 0Ch,f → no write, no done, re-enters CLEAR; opcode 2800h (GOTO) → done with unsupported=1, no state change.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC16-class execute unit: opcode fields, SFR map,
// STATUS bit positions, FSM states and the 8-bit add helper used by the ALU.
package pic_pkg;

    localparam logic [6:0] ADDR_INDF     = 7'h00;
    localparam logic [6:0] ADDR_STATUS   = 7'h03;
    localparam logic [6:0] ADDR_FSR      = 7'h04;
    localparam logic [6:0] ADDR_GPR_BASE = 7'h0C;

    localparam int STAT_C   = 0;
    localparam int STAT_DC  = 1;
    localparam int STAT_Z   = 2;
    localparam int STAT_PD  = 3;
    localparam int STAT_TO  = 4;
    localparam int STAT_RP0 = 5;
    localparam int STAT_RP1 = 6;
    localparam int STAT_IRP = 7;

    localparam logic [7:0] STATUS_RESET = 8'h18;

    // Flag masks line up with STATUS[2:0] = {Z, DC, C}
    localparam logic [2:0] FLAG_NONE = 3'b000;
    localparam logic [2:0] FLAG_C    = 3'b001;
    localparam logic [2:0] FLAG_Z    = 3'b100;
    localparam logic [2:0] FLAG_ALL  = 3'b111;

    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_CTRL = 2'b10;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    localparam logic [3:0] OP_MOVWF_NOP = 4'h0;
    localparam logic [3:0] OP_CLR       = 4'h1;
    localparam logic [3:0] OP_SUBWF     = 4'h2;
    localparam logic [3:0] OP_DECF      = 4'h3;
    localparam logic [3:0] OP_IORWF     = 4'h4;
    localparam logic [3:0] OP_ANDWF     = 4'h5;
    localparam logic [3:0] OP_XORWF     = 4'h6;
    localparam logic [3:0] OP_ADDWF     = 4'h7;
    localparam logic [3:0] OP_MOVF      = 4'h8;
    localparam logic [3:0] OP_COMF      = 4'h9;
    localparam logic [3:0] OP_INCF      = 4'hA;
    localparam logic [3:0] OP_DECFSZ    = 4'hB;
    localparam logic [3:0] OP_RRF       = 4'hC;
    localparam logic [3:0] OP_RLF       = 4'hD;
    localparam logic [3:0] OP_SWAPF     = 4'hE;
    localparam logic [3:0] OP_INCFSZ    = 4'hF;

    localparam logic [1:0] BOP_BCF   = 2'b00;
    localparam logic [1:0] BOP_BSF   = 2'b01;
    localparam logic [1:0] BOP_BTFSC = 2'b10;
    localparam logic [1:0] BOP_BTFSS = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    typedef struct packed {
        logic [7:0] sum;
        logic       c;
        logic       dc;
    } alu_sum_t;

    // Subtraction is a + ~b + 1, so carry out doubles as "no borrow"
    function automatic alu_sum_t add8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        alu_sum_t   r;
        logic [8:0] full;
        logic [4:0] low;
        full = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        low  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, cin};
        r.sum = full[7:0];
        r.c   = full[8];
        r.dc  = low[4];
        return r;
    endfunction

endpackage

// File: rtl/pic_alu_core.sv
// Combinational PIC16 operation decode and datapath: produces the result,
// flag values, flag write mask, destination, skip and unsupported indication.
module pic_alu_core
    import pic_pkg::*;
(
    input  logic [13:0] instr,
    input  logic [7:0]  w,
    input  logic [7:0]  f_val,
    input  logic        c_in,
    output logic [7:0]  result,
    output logic        c_out,
    output logic        dc_out,
    output logic        z_out,
    output logic [2:0]  writes_flags,
    output logic        dest_w,
    output logic        dest_f,
    output logic        skip,
    output logic        unsupported
);

    logic       d_bit;
    logic [7:0] k;
    logic [7:0] bit_mask;
    alu_sum_t   add_fw;
    alu_sum_t   sub_fw;
    alu_sum_t   add_kw;
    alu_sum_t   sub_kw;

    assign d_bit    = instr[7];
    assign k        = instr[7:0];
    assign bit_mask = 8'h01 << instr[9:7];
    assign add_fw   = add8(f_val, w, 1'b0);
    assign sub_fw   = add8(f_val, ~w, 1'b1);
    assign add_kw   = add8(k, w, 1'b0);
    assign sub_kw   = add8(k, ~w, 1'b1);
    assign z_out    = (result == 8'h00);

    // Opcode decode and datapath
    always_comb begin
        result       = 8'h00;
        c_out        = c_in;
        dc_out       = 1'b0;
        writes_flags = FLAG_NONE;
        dest_w       = 1'b0;
        dest_f       = 1'b0;
        skip         = 1'b0;
        unsupported  = 1'b0;
        case (instr[13:12])
            CLS_BYTE: begin
                dest_w = ~d_bit;
                dest_f = d_bit;
                case (instr[11:8])
                    OP_MOVWF_NOP: begin
                        dest_w = 1'b0;
                        if (d_bit) begin
                            result = w;
                            dest_f = 1'b1;
                        end else if (instr[4:0] == 5'h00) begin
                            dest_f = 1'b0;
                        end else begin
                            dest_f      = 1'b0;
                            unsupported = 1'b1;
                        end
                    end
                    OP_CLR: begin
                        result = 8'h00;
                        writes_flags = FLAG_Z;
                    end
                    OP_SUBWF: begin
                        result = sub_fw.sum;
                        c_out  = sub_fw.c;
                        dc_out = sub_fw.dc;
                        writes_flags = FLAG_ALL;
                    end
                    OP_DECF: begin
                        result = f_val - 8'h01;
                        writes_flags = FLAG_Z;
                    end
                    OP_IORWF: begin
                        result = f_val | w;
                        writes_flags = FLAG_Z;
                    end
                    OP_ANDWF: begin
                        result = f_val & w;
                        writes_flags = FLAG_Z;
                    end
                    OP_XORWF: begin
                        result = f_val ^ w;
                        writes_flags = FLAG_Z;
                    end
                    OP_ADDWF: begin
                        result = add_fw.sum;
                        c_out  = add_fw.c;
                        dc_out = add_fw.dc;
                        writes_flags = FLAG_ALL;
                    end
                    OP_MOVF: begin
                        result = f_val;
                        writes_flags = FLAG_Z;
                    end
                    OP_COMF: begin
                        result = ~f_val;
                        writes_flags = FLAG_Z;
                    end
                    OP_INCF: begin
                        result = f_val + 8'h01;
                        writes_flags = FLAG_Z;
                    end
                    OP_DECFSZ: begin
                        result = f_val - 8'h01;
                        skip   = (f_val == 8'h01);
                    end
                    OP_RRF: begin
                        result = {c_in, f_val[7:1]};
                        c_out  = f_val[0];
                        writes_flags = FLAG_C;
                    end
                    OP_RLF: begin
                        result = {f_val[6:0], c_in};
                        c_out  = f_val[7];
                        writes_flags = FLAG_C;
                    end
                    OP_SWAPF: begin
                        result = {f_val[3:0], f_val[7:4]};
                    end
                    OP_INCFSZ: begin
                        result = f_val + 8'h01;
                        skip   = (f_val == 8'hFF);
                    end
                    default: begin
                        dest_w      = 1'b0;
                        dest_f      = 1'b0;
                        unsupported = 1'b1;
                    end
                endcase
            end
            CLS_BIT: begin
                case (instr[11:10])
                    BOP_BCF: begin
                        result = f_val & ~bit_mask;
                        dest_f = 1'b1;
                    end
                    BOP_BSF: begin
                        result = f_val | bit_mask;
                        dest_f = 1'b1;
                    end
                    BOP_BTFSC: skip = ((f_val & bit_mask) == 8'h00);
                    BOP_BTFSS: skip = ((f_val & bit_mask) != 8'h00);
                    default:   unsupported = 1'b1;
                endcase
            end
            CLS_LIT: begin
                dest_w = 1'b1;
                casez (instr[11:8])
                    4'b00??: result = k;
                    4'b1000: begin
                        result = k | w;
                        writes_flags = FLAG_Z;
                    end
                    4'b1001: begin
                        result = k & w;
                        writes_flags = FLAG_Z;
                    end
                    4'b1010: begin
                        result = k ^ w;
                        writes_flags = FLAG_Z;
                    end
                    4'b110?: begin
                        result = sub_kw.sum;
                        c_out  = sub_kw.c;
                        dc_out = sub_kw.dc;
                        writes_flags = FLAG_ALL;
                    end
                    4'b111?: begin
                        result = add_kw.sum;
                        c_out  = add_kw.c;
                        dc_out = add_kw.dc;
                        writes_flags = FLAG_ALL;
                    end
                    default: begin
                        dest_w      = 1'b0;
                        unsupported = 1'b1;
                    end
                endcase
            end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/pic_exec_unit.sv
// PIC16-class execute unit: instruction handshake, CLEAR/READ/EXEC/WRITE
// sequencing, W/STATUS/FSR, banked GPR file and indirect addressing.
module pic_exec_unit
    import pic_pkg::*;
#(
    parameter int  NUM_BANKS = 2,
    parameter int  GPR_DEPTH = 68,
    localparam int ADDR_W    = 7 + $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [13:0]       instr,
    output logic              done,
    output logic              skip,
    output logic              unsupported,
    output logic [7:0]        w_reg,
    output logic [7:0]        status,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int GPR_TOTAL = NUM_BANKS * GPR_DEPTH;
    localparam int IDX_W     = (GPR_TOTAL > 1) ? $clog2(GPR_TOTAL) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
    logic [13:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ea_q, ea_d;
    logic [7:0]        opnd_q, opnd_d;
    logic [7:0]        w_q, w_d;
    logic [7:0]        status_q, status_d;
    logic [7:0]        fsr_q, fsr_d;
    logic [7:0]        res_q, res_d;
    logic [2:0]        flags_q, flags_d;
    logic [2:0]        fmask_q, fmask_d;
    logic              dest_w_q, dest_w_d;
    logic              dest_f_q, dest_f_d;
    logic              done_q, done_d;
    logic              skip_q, skip_d;
    logic              unsup_q, unsup_d;
    logic [7:0]        gpr_q [GPR_TOTAL];
    logic [7:0]        gpr_d [GPR_TOTAL];

    logic [ADDR_W-1:0] op_ea;
    logic [7:0]        status_wr;
    logic [7:0]        alu_result;
    logic              alu_c, alu_dc, alu_z;
    logic [2:0]        alu_fmask;
    logic              alu_dest_w, alu_dest_f, alu_skip, alu_unsup;

    function automatic logic gpr_hit(input logic [ADDR_W-1:0] ea);
        return (int'(ea[6:0]) >= int'(ADDR_GPR_BASE)) &&
               (int'(ea[6:0]) < int'(ADDR_GPR_BASE) + GPR_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] gpr_index(input logic [ADDR_W-1:0] ea);
        return IDX_W'((int'(ea) >> 7) * GPR_DEPTH + int'(ea[6:0]) - int'(ADDR_GPR_BASE));
    endfunction

    // INDF itself, unused SFR slots and addresses past the GPR range all read as zero
    function automatic logic [7:0] read_map(input logic [ADDR_W-1:0] ea);
        logic [7:0] val;
        if (ea[6:0] == ADDR_STATUS) begin
            val = status_q;
        end else if (ea[6:0] == ADDR_FSR) begin
            val = fsr_q;
        end else if (gpr_hit(ea)) begin
            val = gpr_q[gpr_index(ea)];
        end else begin
            val = 8'h00;
        end
        return val;
    endfunction

    pic_alu_core u_alu (
        .instr        (instr_q),
        .w            (w_q),
        .f_val        (opnd_q),
        .c_in         (status_q[STAT_C]),
        .result       (alu_result),
        .c_out        (alu_c),
        .dc_out       (alu_dc),
        .z_out        (alu_z),
        .writes_flags (alu_fmask),
        .dest_w       (alu_dest_w),
        .dest_f       (alu_dest_f),
        .skip         (alu_skip),
        .unsupported  (alu_unsup)
    );

    // Effective address of the latched instruction: indirect through FSR when f is INDF
    always_comb begin
        if (instr_q[6:0] == ADDR_INDF) begin
            op_ea = ADDR_W'({status_q[STAT_IRP], fsr_q});
        end else begin
            op_ea = ADDR_W'({status_q[STAT_RP1], status_q[STAT_RP0], instr_q[6:0]});
        end
    end

    // A STATUS destination keeps TO/PD; computed flags then override their own bits
    always_comb begin
        if (dest_f_q && (ea_q[6:0] == ADDR_STATUS)) begin
            status_wr = {res_q[7:5], status_q[STAT_TO], status_q[STAT_PD], res_q[2:0]};
        end else begin
            status_wr = status_q;
        end
    end

    // FSM next state, register file update and completion report
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        instr_d   = instr_q;
        ea_d      = ea_q;
        opnd_d    = opnd_q;
        w_d       = w_q;
        status_d  = status_q;
        fsr_d     = fsr_q;
        res_d     = res_q;
        flags_d   = flags_q;
        fmask_d   = fmask_q;
        dest_w_d  = dest_w_q;
        dest_f_d  = dest_f_q;
        done_d    = 1'b0;
        skip_d    = 1'b0;
        unsup_d   = 1'b0;
        gpr_d     = gpr_q;
        case (state_q)
            ST_CLEAR: begin
                gpr_d[clr_idx_q] = 8'h00;
                if (clr_idx_q == IDX_W'(GPR_TOTAL - 1)) begin
                    clr_idx_d = {IDX_W{1'b0}};
                    state_d   = ST_IDLE;
                end else begin
                    clr_idx_d = clr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                ea_d    = op_ea;
                opnd_d  = read_map(op_ea);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                res_d    = alu_result;
                flags_d  = {alu_z, alu_dc, alu_c};
                fmask_d  = alu_fmask;
                dest_w_d = alu_dest_w;
                dest_f_d = alu_dest_f;
                done_d   = 1'b1;
                skip_d   = alu_skip;
                unsup_d  = alu_unsup;
                state_d  = ST_WRITE;
            end
            ST_WRITE: begin
                if (dest_w_q) begin
                    w_d = res_q;
                end else begin
                    w_d = w_q;
                end
                status_d = (status_wr & ~{5'b00000, fmask_q}) | {5'b00000, flags_q & fmask_q};
                if (dest_f_q && (ea_q[6:0] == ADDR_FSR)) begin
                    fsr_d = res_q;
                end else begin
                    fsr_d = fsr_q;
                end
                if (dest_f_q && gpr_hit(ea_q)) begin
                    gpr_d[gpr_index(ea_q)] = res_q;
                end else begin
                    gpr_d = gpr_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                clr_idx_d = {IDX_W{1'b0}};
                state_d   = ST_CLEAR;
            end
        endcase
    end

    // Control and architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= {IDX_W{1'b0}};
            instr_q   <= 14'h0000;
            ea_q      <= {ADDR_W{1'b0}};
            opnd_q    <= 8'h00;
            w_q       <= 8'h00;
            status_q  <= STATUS_RESET;
            fsr_q     <= 8'h00;
            res_q     <= 8'h00;
            flags_q   <= 3'b000;
            fmask_q   <= 3'b000;
            dest_w_q  <= 1'b0;
            dest_f_q  <= 1'b0;
            done_q    <= 1'b0;
            skip_q    <= 1'b0;
            unsup_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            instr_q   <= instr_d;
            ea_q      <= ea_d;
            opnd_q    <= opnd_d;
            w_q       <= w_d;
            status_q  <= status_d;
            fsr_q     <= fsr_d;
            res_q     <= res_d;
            flags_q   <= flags_d;
            fmask_q   <= fmask_d;
            dest_w_q  <= dest_w_d;
            dest_f_q  <= dest_f_d;
            done_q    <= done_d;
            skip_q    <= skip_d;
            unsup_q   <= unsup_d;
        end
    end

    // GPR storage is zeroed by the CLEAR walk, so reset only blocks pending writes
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_q <= gpr_q;
        end else begin
            gpr_q <= gpr_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign done        = done_q;
    assign skip        = skip_q;
    assign unsupported = unsup_q;
    assign w_reg       = w_q;
    assign status      = status_q;
    assign dbg_data    = read_map(dbg_addr);

endmodule
